// File: rtl/register16_skid.sv
// Pipeline register stage with valid/ready handshake and a one-entry skid buffer.
// in_ready, out_valid, level and out_data all come straight from flops.
module register16_skid #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] skid;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // out_data is the main register; skid holds the second word while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_data  <= '0;
      skid      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      level     <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            out_data  <= in_data;
            state     <= ONE;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
            level     <= 2'd1;
          end
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            skid     <= in_data;
            state    <= FULL;
            in_ready <= 1'b0;
            level    <= 2'd2;
          end else if (!in_xfer && out_xfer) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            level     <= 2'd0;
          end else if (in_xfer && out_xfer) begin
            out_data <= in_data;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain can happen
          if (out_xfer) begin
            out_data <= skid;
            state    <= ONE;
            in_ready <= 1'b1;
            level    <= 2'd1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          level     <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register16_skid.sv
// Directed self-checking bench for register16_skid.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_register16_skid;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  level;

  int checks = 0;
  int errors = 0;

  register16_skid #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hFFFF;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h exp 0000", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_data   = 16'h1234;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = 16'hxxxx;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 16'h1234) begin errors++; $display("FAIL single_out_data got %h exp 1234", out_data); end
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL single_level got %0d exp 1", level); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got %b exp 0", out_valid); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL single_drain_level got %0d exp 0", level); end
    checks++; if (out_data !== 16'h1234) begin errors++; $display("FAIL single_x_hold got %h exp 1234", out_data); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data  = 16'(i + 1);
      in_valid = 1'b1;
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== 16'(i + 1)) begin errors++; $display("FAIL stream_word%0d got %b/%h exp 1/%h", i, out_valid, out_data, 16'(i + 1)); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready%0d got %b exp 1", i, in_ready); end
      checks++; if (level !== 2'd1) begin errors++; $display("FAIL stream_level%0d got %0d exp 1", i, level); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL stream_drain_level got %0d exp 0", level); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_data   = 16'hAAAA;
    in_valid  = 1'b1;
    step();
    checks++; if (level !== 2'd1 || out_data !== 16'hAAAA) begin errors++; $display("FAIL bp_first got %0d/%h exp 1/aaaa", level, out_data); end
    in_data = 16'h5555;
    step();
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL bp_full_level got %0d exp 2", level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %b exp 0", in_ready); end
    checks++; if (out_data !== 16'hAAAA) begin errors++; $display("FAIL bp_full_data got %h exp aaaa", out_data); end
    in_data = 16'hBEEF;
    repeat (2) begin
      step();
      checks++; if (level !== 2'd2 || out_valid !== 1'b1 || out_data !== 16'hAAAA) begin errors++; $display("FAIL bp_stall got %0d/%b/%h exp 2/1/aaaa", level, out_valid, out_data); end
    end
    out_ready = 1'b1;
    step();
    checks++; if (out_data !== 16'h5555 || level !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain1 got %h/%0d/%b exp 5555/1/1", out_data, level, in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_data !== 16'hBEEF || level !== 2'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain2 got %h/%0d/%b exp beef/1/1", out_data, level, out_valid); end
    step();
    checks++; if (level !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0d/%b exp 0/0", level, out_valid); end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    in_data   = 16'h00FF;
    in_valid  = 1'b1;
    step();
    checks++; if (out_data !== 16'h00FF || level !== 2'd1) begin errors++; $display("FAIL sim_load got %h/%0d exp 00ff/1", out_data, level); end
    in_data   = 16'hFF00;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_data !== 16'hFF00 || level !== 2'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL sim_both got %h/%0d/%b exp ff00/1/1", out_data, level, out_valid); end
    step();
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL sim_empty got %0d exp 0", level); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_data   = 16'hAAAA;
    in_valid  = 1'b1;
    step();
    in_data = 16'h5555;
    step();
    in_valid = 1'b0;
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL mid_full got %0d exp 2", level); end
    rst_n     = 1'b0;
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    checks++; if (level !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_state got %0d/%b exp 0/0", level, out_valid); end
    checks++; if (out_data !== 16'h0000 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_data got %h/%b exp 0000/1", out_data, in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0 || level !== 2'd0) begin errors++; $display("FAIL mid_no_emit%0d got %b/%0d exp 0/0", i, out_valid, level); end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register16_skid.md
Name: register16_skid

Overview:
- 16-bit pipeline register stage with a valid/ready handshake and a one-entry skid buffer.
- Sits directly upstream of the 16-bit bitwise inverter. It registers ALU operand words and presents them on out_data, which drives the inverter input.
- Decouples producer and consumer timing: sustains one word per cycle, with in_ready fully registered so there is no combinational ready path.

Parameters:
- WIDTH, 16, data word width in bits. Only 16 is required for integration; other values must still elaborate.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- in_data  input  WIDTH  word from producer.
- in_valid  input  1  producer asserts when in_data is valid.
- in_ready  output  1  stage can accept a word this cycle. Registered.
- out_data  output  WIDTH  word to consumer (inverter input). Registered.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- level  output  2  words held: 0, 1 or 2.

Behaviour:
- Transfers: in-transfer = in_valid & in_ready; out-transfer = out_valid & out_ready. Both are evaluated at the rising edge.
- Storage: main register M (drives out_data) and skid register S.
- States:
  - EMPTY (level 0): out_valid=0, in_ready=1.
  - ONE (level 1): out_valid=1, in_ready=1.
  - FULL (level 2): out_valid=1, in_ready=0.
- Transitions:
  - EMPTY, in-xfer: M<=in_data, go to ONE.
  - ONE, in-xfer without out-xfer: S<=in_data, go to FULL.
  - ONE, out-xfer without in-xfer: go to EMPTY.
  - ONE, both: M<=in_data, stay in ONE.
  - FULL, out-xfer: M<=S, go to ONE. No in-xfer is possible because in_ready=0.
  - Otherwise: hold.
- Latency: a word accepted at edge N appears on out_data with out_valid=1 after edge N. Minimum latency is 1 cycle.
- Throughput: 1 word/cycle whenever out_ready is held high.
- Ordering: strict FIFO. No word is dropped or duplicated.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold constant.
- In EMPTY, out_data retains its last value; consumers must qualify it with out_valid.
- in_valid while in_ready=0 is ignored. The producer must hold the word until it is accepted.
- Reset (rst_n=0 at an edge):
  - Next state is EMPTY, level=0, out_valid=0, in_ready=1, out_data=0, S=0.
  - Reset overrides any simultaneous transfer.
  - Reset mid-stream discards all held words.
- While rst_n is low, in-transfers are not captured.
- X on in_data while in_valid=0 must not propagate to out_data.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with in_valid=1, in_data=16'hFFFF -> after release out_valid=0, out_data=16'h0000, in_ready=1, level=0.
2. Single word: in_data=16'h1234 for one cycle, out_ready=1 -> out_valid=1 and out_data=16'h1234 exactly one cycle later, then EMPTY.
3. Streaming: 8 back-to-back words 16'h0001..16'h0008 with out_ready=1 -> 8 consecutive out-transfers in order, in_ready never drops, level stays 1.
4. Backpressure: out_ready=0, send 16'hAAAA then 16'h5555 -> level=2, in_ready=0, out_data holds 16'hAAAA. A third word 16'hBEEF offered is not accepted. Raise out_ready -> outputs 16'hAAAA, 16'h5555, 16'hBEEF in order.
5. Simultaneous in/out in ONE: M=16'h00FF, in_data=16'hFF00, both transfers -> next cycle out_data=16'hFF00, level=1.
6. Reset mid-operation: in FULL holding 16'hAAAA and 16'h5555, pulse rst_n=0 for one edge -> level=0, out_valid=0, out_data=0. Both words are never emitted.
